vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares one single-port synchronous video RAM between the VGA scan-out controller (pixel reads) and a game/CPU writer (pixel writes). Scan-out reads always win. Writes are buffered in a small FIFO and drained only in cycles with no scan-out read. After reset the block clears the whole frame buffer to a fixed colour, and it emits a per-frame tick so game logic can update between frames.

## Interface
Parameters:
- `SCALE`, 1: pixel replication shift; the buffer is (640>>SCALE) x (480>>SCALE) words.
- `ADDR_W`, 17: RAM address width; must hold 76800 words for `SCALE`=1.
- `FIFO_DEPTH`, 4: write FIFO entries; power of two, at least 2.
- `CLEAR_COLOR`, 12'h000: colour written everywhere after reset.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-low reset.
- `vga_row` in 9: scan-out row, 0..479.
- `vga_col` in 10: scan-out column, 0..639.
- `vga_rdn` in 1: active-low read strobe from scan-out.
- `vga_din` out 12: pixel data {B,G,R} returned to scan-out.
- `wr_valid` in 1: writer presents a pixel write.
- `wr_ready` out 1: write accepted in this cycle.
- `wr_addr` in ADDR_W: linear buffer address.
- `wr_data` in 12: pixel colour.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 12: RAM write data.
- `mem_rdata` in 12: RAM read data, one cycle after address.
- `clear_done` out 1: high once the post-reset clear has finished.
- `frame_tick` out 1: one-cycle pulse at the end of each active frame.

## Operation
- Read address: (vga_row>>SCALE)*(640>>SCALE) + (vga_col>>SCALE). Compute it with shift-adds, no multiplier. The result is truncated to ADDR_W.
- Each cycle the RAM slot goes to exactly one user, in this priority order:
  1. Scan-out read, when vga_rdn=0. mem_we=0 and mem_addr is the read address, driven combinationally.
  2. CLEAR write, in state CLEAR.
  3. FIFO head write, in state RUN when the FIFO is not empty. The entry is popped in that cycle.
  4. Idle. mem_we=0 and mem_addr holds its last value.
- FSM states:
  - CLEAR (entered on reset): clear pointer steps 0..DEPTH-1 (DEPTH = (640>>SCALE)*(480>>SCALE)), one word per granted slot. Go to RUN after writing DEPTH-1.
  - RUN: normal operation; there is no return to CLEAR except by reset.
- clear_done=0 in CLEAR and 1 in RUN.
- Write handshake: wr_ready = clear_done && FIFO not full. A transfer occurs when wr_valid && wr_ready.
- Push and pop in the same cycle are allowed and leave the count unchanged.
- When full, wr_ready=0 combinationally; a push and a pop in the same cycle is not possible in this state.
- wr_addr >= DEPTH is accepted and written unchanged; the RAM wraps it. This is a writer error and is not checked.
- frame_tick fires in the cycle after the scan-out read with vga_row=479 and vga_col=639. Detect it with a registered flag.

## Timing
- vga_din is registered from mem_rdata. A read strobed in cycle t appears on vga_din at t+1, matching scan-out's one-cycle registered rdn.
- vga_din holds its value in non-read cycles.
- Write latency from acceptance to RAM write is at least 1 cycle. In blanking with an empty FIFO it is exactly 1 cycle: pushed at t, written at t+1.
- Values while rst=0:
  - Outputs: vga_din=0, mem_we=0, mem_addr=0, mem_wdata=0, clear_done=0, frame_tick=0, wr_ready=0.
  - Internal: FIFO empty, clear pointer 0.
- Reset asserted mid-CLEAR or mid-RUN aborts everything. FIFO contents are discarded and the clear restarts from 0.
- Worst case, writes wait a full active line (640 cycles). A writer that sustains more than FIFO_DEPTH writes per line sees wr_ready=0 and must hold wr_valid and its data.

## Structure
- Shared package `vga_pkg` holds:
  - H_ACTIVE=640, V_ACTIVE=480, the pixel width (12), and DEPTH derived from SCALE.
  - The FSM enum {CLEAR, RUN}.
- One sub-module, `sync_fifo`: parameterised width (ADDR_W+12) and depth; ports push, pop, full, empty, dout. The head entry is visible on dout without a read-latency cycle.
- Address computation and priority mux live in `vram_arbiter`.

## Test plan
- Reset, then idle scan-out (vga_rdn=1):
  - mem_we=1 for exactly 76800 consecutive cycles, with addresses 0..76799 and data 12'h000.
  - clear_done rises the next cycle.
- During CLEAR, drive vga_rdn=0 for 10 cycles:
  - Those cycles are reads and the clear pointer is frozen.
  - The total write count is still 76800.
- In RUN, write 8 pixels back-to-back during active video (FIFO_DEPTH=4):
  - wr_ready drops after 4 accepts and mem_we stays 0.
  - When vga_rdn goes high, 4 writes drain on consecutive cycles and wr_ready recovers.
- Write 12'hABC at address 1000 during blanking, then read row=6, col=500 (SCALE=1, address 3*320+250=1210) after writing 12'h5A5 at 1210:
  - vga_din=12'h5A5 one cycle after the strobe.
- Push and pop in the same cycle with the FIFO at count 2:
  - The count stays 2 and the data order is preserved.
- Read with row=479, col=639:
  - frame_tick is a single-cycle pulse in the next cycle; there is no pulse on any other address.
- Assert rst with the FIFO holding 3 entries:
  - No stale writes after release; CLEAR restarts at address 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the frame-buffer arbiter: visible geometry,
// pixel width, arbiter states and the buffer depth for a given replication shift.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned PIX_W    = 12;

  typedef enum logic {
    CLEAR,
    RUN
  } arb_state_e;

  function automatic int unsigned buf_depth(input int unsigned scale);
    return (H_ACTIVE >> scale) * (V_ACTIVE >> scale);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO: the head entry is always visible on dout.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and the count/pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: scan-out reads win, then the post-reset clear,
// then buffered pixel writes. Also emits a one-cycle tick after each frame's last read.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int               SCALE       = 1,
  parameter int               ADDR_W      = 17,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        vga_row,
  input  logic [9:0]        vga_col,
  input  logic              vga_rdn,
  output logic [PIX_W-1:0]  vga_din,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              clear_done,
  output logic              frame_tick
);

  localparam int unsigned       DEPTH     = buf_depth(SCALE);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
  localparam int                ENTRY_W   = ADDR_W + PIX_W;
  // Row stride 640>>SCALE split as (512>>SCALE)+(128>>SCALE): two shifts, no multiplier.
  localparam int                SH_HI     = 9 - SCALE;
  localparam int                SH_LO     = 7 - SCALE;

  arb_state_e         state;
  logic [ADDR_W-1:0]  clr_ptr;
  logic [ADDR_W-1:0]  last_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic [8:0]         row_s;
  logic [9:0]         col_s;
  logic               rd_req;
  logic               clr_wr;
  logic               fifo_wr;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               rd_q;
  logic [PIX_W-1:0]   din_q;

  assign row_s   = vga_row >> SCALE;
  assign col_s   = vga_col >> SCALE;
  assign rd_addr = (ADDR_W'(row_s) << SH_HI) + (ADDR_W'(row_s) << SH_LO) + ADDR_W'(col_s);

  // Grants are qualified by rst so nothing reaches the RAM while reset is held.
  assign rd_req     = rst && !vga_rdn;
  assign clr_wr     = rst && !rd_req && (state == CLEAR);
  assign fifo_wr    = !rd_req && (state == RUN) && !fifo_empty;
  assign mem_we     = clr_wr || fifo_wr;
  assign clear_done = (state == RUN);
  assign wr_ready   = clear_done && !fifo_full;
  assign push       = wr_valid && wr_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_wr),
    .din   ({wr_addr, wr_data}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    mem_addr  = last_addr;
    mem_wdata = '0;
    if (rd_req) begin
      mem_addr = rd_addr;
    end else if (clr_wr) begin
      mem_addr  = clr_ptr;
      mem_wdata = CLEAR_COLOR;
    end else if (fifo_wr) begin
      mem_addr  = fifo_head[ENTRY_W-1:PIX_W];
      mem_wdata = fifo_head[PIX_W-1:0];
    end
  end

  // RAM data lands the cycle after the strobe; rd_q selects it then, din_q holds it after.
  assign vga_din = rd_q ? mem_rdata : din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      last_addr  <= '0;
      rd_q       <= 1'b0;
      din_q      <= '0;
      frame_tick <= 1'b0;
    end else begin
      last_addr  <= mem_addr;
      rd_q       <= rd_req;
      din_q      <= vga_din;
      frame_tick <= rd_req && (vga_row == 9'(V_ACTIVE - 1)) && (vga_col == 10'(H_ACTIVE - 1));
      if (clr_wr) begin
        if (clr_ptr == LAST_WORD) state <= RUN;
        else                      clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, queue-based reference of the arbitration
// rules checked every cycle, plus directed scenarios with literal expectations.
module tb_vram_arbiter;

  localparam int          SCALE       = 1;
  localparam int          ADDR_W      = 17;
  localparam int          FIFO_DEPTH  = 4;
  localparam logic [11:0] CLEAR_COLOR = 12'h000;
  localparam int          DEPTH       = (640 >> SCALE) * (480 >> SCALE);

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [11:0]       data;
  } pix_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [8:0]        vga_row;
  logic [9:0]        vga_col;
  logic              vga_rdn;
  logic [11:0]       vga_din;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [11:0]       mem_wdata;
  logic [11:0]       mem_rdata = 12'h000;
  logic              clear_done;
  logic              frame_tick;

  always #5 clk = ~clk;

  vram_arbiter #(
    .SCALE       (SCALE),
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLEAR_COLOR (CLEAR_COLOR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_row    (vga_row),
    .vga_col    (vga_col),
    .vga_rdn    (vga_rdn),
    .vga_din    (vga_din),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .clear_done (clear_done),
    .frame_tick (frame_tick)
  );

  // Synchronous single-port RAM
  logic [11:0] ram [1 << ADDR_W];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  pix_t              m_q[$];
  int                m_clr;
  logic [ADDR_W-1:0] m_last;
  logic [11:0]       m_din;
  logic              m_tick;
  logic [11:0]       shadow [1 << ADDR_W];

  // Observations used by the directed checks
  int                n_clr_wr;
  int                n_run_wr;
  int                clr_cycles;
  int                stale_hits;
  logic [ADDR_W-1:0] last_clr_addr;
  logic [ADDR_W-1:0] run_addrs[$];

  always @(negedge clk) begin : model_b
    logic              rd;
    logic              ewe;
    logic              edone;
    logic              erdy;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] ea;
    logic [11:0]       ed;
    if (!rst) begin
      check("rst_vga_din", int'(vga_din), 0);
      check("rst_mem_we", int'(mem_we), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_mem_wdata", int'(mem_wdata), 0);
      check("rst_clear_done", int'(clear_done), 0);
      check("rst_frame_tick", int'(frame_tick), 0);
      check("rst_wr_ready", int'(wr_ready), 0);
      m_q.delete();
      m_clr = 0; m_last = '0; m_din = '0; m_tick = 1'b0;
      n_clr_wr = 0; clr_cycles = 0; stale_hits = 0;
    end else begin
      rd    = !vga_rdn;
      ra    = ADDR_W'((int'(vga_row) >> SCALE) * (640 >> SCALE) + (int'(vga_col) >> SCALE));
      edone = (m_clr == DEPTH);
      erdy  = edone && (m_q.size() < FIFO_DEPTH);
      ewe   = 1'b0;
      ed    = '0;
      ea    = m_last;
      if (rd) begin
        ea = ra;
      end else if (!edone) begin
        ewe = 1'b1; ea = ADDR_W'(m_clr); ed = CLEAR_COLOR;
      end else if (m_q.size() != 0) begin
        ewe = 1'b1; ea = m_q[0].addr; ed = m_q[0].data;
      end
      check("mem_we", int'(mem_we), int'(ewe));
      check("mem_addr", int'(mem_addr), int'(ea));
      if (ewe) check("mem_wdata", int'(mem_wdata), int'(ed));
      check("wr_ready", int'(wr_ready), int'(erdy));
      check("clear_done", int'(clear_done), int'(edone));
      check("frame_tick", int'(frame_tick), int'(m_tick));
      check("vga_din", int'(vga_din), int'(m_din));

      if (mem_we && !clear_done) begin n_clr_wr++; last_clr_addr = mem_addr; end
      if (mem_we && clear_done)  begin n_run_wr++; run_addrs.push_back(mem_addr); end
      if (mem_we && mem_addr >= 5000 && mem_addr <= 5002) stale_hits++;
      if (!clear_done) clr_cycles++;

      if (ewe) begin
        shadow[ea] = ed;
        if (!edone) m_clr++;
        else void'(m_q.pop_front());
      end
      if (wr_valid && erdy) m_q.push_back('{wr_addr, wr_data});
      m_last = ea;
      m_tick = rd && (vga_row == 9'd479) && (vga_col == 10'd639);
      if (rd) m_din = shadow[ra];
    end
  end

  // Writer: presents queued pixels, holding each until accepted
  pix_t tx_q[$];
  int   n_acc = 0;
  logic acc;

  initial begin : writer_b
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    forever begin
      @(negedge clk);
      acc = wr_valid && wr_ready;
      if (acc) n_acc++;
      @(posedge clk); #2;
      if (acc) void'(tx_q.pop_front());
      if (tx_q.size() != 0) begin
        wr_valid = 1'b1; wr_addr = tx_q[0].addr; wr_data = tx_q[0].data;
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic queue_px(input int a, input int d);
    tx_q.push_back('{ADDR_W'(a), 12'(d)});
  endtask

  initial begin : main_b
    int k;
    int a0;
    int w0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = 12'h000;
      shadow[i] = 12'h000;
    end
    vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
    repeat (3) step();

    // Clear after reset, interrupted by 10 scan-out reads
    rst = 1'b1;
    settle();
    check("clear_first_we", int'(mem_we), 1);
    check("clear_first_addr", int'(mem_addr), 0);
    repeat (50) step();
    for (int i = 0; i < 10; i++) begin
      step(); vga_rdn = 1'b0; vga_col = 10'(i);
      settle();
      check("clear_read_no_we", int'(mem_we), 0);
    end
    step(); vga_rdn = 1'b1;
    k = 0;
    while (clear_done !== 1'b1 && k < 80000) begin settle(); k++; end
    check("clear_done_rise", int'(clear_done), 1);
    check("clear_write_count", n_clr_wr, 76800);
    check("clear_last_addr", int'(last_clr_addr), 76799);
    check("clear_cycles", clr_cycles, 76810);
    check("run_ready", int'(wr_ready), 1);

    // 8 back-to-back writes during active video
    step(); vga_rdn = 1'b0; vga_row = 9'd100; vga_col = '0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) queue_px(2000 + i, 12'h100 + i);
    settle();
    for (int i = 1; i < 8; i++) begin step(); vga_col = 10'(i); settle(); end
    check("fill_accepts", n_acc - a0, 4);
    check("fill_ready_low", int'(wr_ready), 0);
    check("fill_no_we", int'(mem_we), 0);
    w0 = n_run_wr;
    step(); vga_rdn = 1'b1;
    settle();
    check("drain_we", int'(mem_we), 1);
    check("drain_addr", int'(mem_addr), 2000);
    check("drain_data", int'(mem_wdata), 12'h100);
    check("drain_ready_full", int'(wr_ready), 0);
    step(); settle();
    check("drain_ready_back", int'(wr_ready), 1);
    repeat (10) begin step(); settle(); end
    check("drain_total", n_run_wr - w0, 8);

    // Blanking write latency, then read-back through the address map
    step(); queue_px(1000, 12'hABC);
    settle();
    check("blank_ready", int'(wr_ready), 1);
    check("blank_push_no_we", int'(mem_we), 0);
    step(); settle();
    check("blank_we", int'(mem_we), 1);
    check("blank_addr", int'(mem_addr), 1000);
    check("blank_data", int'(mem_wdata), 12'hABC);
    step(); queue_px(1210, 12'h5A5);
    repeat (3) begin step(); settle(); end
    step(); vga_rdn = 1'b0; vga_row = 9'd6; vga_col = 10'd500;
    settle();
    check("rd_addr_1210", int'(mem_addr), 1210);
    step(); vga_rdn = 1'b1;
    settle();
    check("rd_din_5a5", int'(vga_din), 12'h5A5);
    step(); vga_rdn = 1'b0; vga_col = 10'd80;
    settle();
    check("rd_addr_1000", int'(mem_addr), 1000);
    step(); vga_rdn = 1'b1;
    settle();
    check("rd_din_abc", int'(vga_din), 12'hABC);
    step(); settle();
    check("din_hold", int'(vga_din), 12'hABC);

    // Simultaneous push and pop at count 2
    run_addrs.delete();
    a0 = n_acc;
    step(); vga_rdn = 1'b0; vga_row = 9'd200; vga_col = '0;
    for (int i = 0; i < 6; i++) queue_px(3000 + i, 12'h300 + i);
    settle();
    step(); vga_col = 10'd1; settle();
    step(); vga_rdn = 1'b1; settle();
    check("pp_pop_addr", int'(mem_addr), 3000);
    check("pp_ready", int'(wr_ready), 1);
    step(); vga_rdn = 1'b0; vga_col = 10'd2; settle();
    step(); vga_col = 10'd3; settle();
    check("pp_ready_cnt3", int'(wr_ready), 1);
    step(); vga_col = 10'd4; settle();
    check("pp_ready_full", int'(wr_ready), 0);
    check("pp_accepts", n_acc - a0, 5);
    step(); vga_rdn = 1'b1;
    repeat (8) begin settle(); step(); end
    check("pp_write_count", run_addrs.size(), 6);
    for (int i = 0; i < 6; i++)
      check("pp_order", (i < run_addrs.size()) ? int'(run_addrs[i]) : -1, 3000 + i);

    // Frame tick
    step(); vga_rdn = 1'b0; vga_row = 9'd478; vga_col = 10'd639; settle();
    step(); vga_row = 9'd479; vga_col = 10'd638; settle();
    check("tick_none_478", int'(frame_tick), 0);
    step(); vga_col = 10'd639; settle();
    check("tick_none_638", int'(frame_tick), 0);
    step(); vga_rdn = 1'b1; settle();
    check("tick_pulse", int'(frame_tick), 1);
    step(); settle();
    check("tick_single", int'(frame_tick), 0);

    // Reset with 3 entries queued: entries are dropped and the clear restarts
    a0 = n_acc;
    step(); vga_rdn = 1'b0; vga_row = 9'd300; vga_col = '0;
    for (int i = 0; i < 3; i++) queue_px(5000 + i, 12'h500 + i);
    settle();
    step(); vga_col = 10'd1; settle();
    step(); vga_col = 10'd2; settle();
    check("rst_fifo_fill", n_acc - a0, 3);
    step(); rst = 1'b0; vga_rdn = 1'b1; settle();
    step(); settle();
    step(); rst = 1'b1; settle();
    check("restart_we", int'(mem_we), 1);
    check("restart_addr", int'(mem_addr), 0);
    check("restart_not_done", int'(clear_done), 0);
    repeat (300) begin step(); settle(); end
    check("restart_clr_count", n_clr_wr, 301);
    check("restart_last_addr", int'(last_clr_addr), 300);
    check("no_stale_writes", stale_hits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
